// File: rtl/serial_pad_reader.sv
//-----------------------------------------------------------------------------
// serial_pad_reader
//
// Polls an NES-style serial gamepad through its latch/clock/data wires and
// produces the debounced, active-low button vector used by the joypad
// register.
//
// Each poll frame runs IDLE -> LATCH -> 8 x (LOW, HIGH) -> DONE. It latches
// the pad, then shifts out eight bits, sampling one on the last cycle of each
// pad_clk low phase. The raw wire order is remapped to the console order.
// Opposing directions can be cleaned (SOCD). The frame then feeds a
// consecutive-frame debouncer before it reaches buttons.
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high
//   pad_latch  out  1  controller latch strobe, active-high (registered)
//   pad_clk    out  1  controller shift clock, idles high (registered)
//   pad_data   in   1  controller serial data, asynchronous, 0 = pressed
//   buttons    out  8  {Start,Select,B,A,Down,Up,Left,Right}, 0 = pressed
//   poll_done  out  1  one-cycle pulse per completed frame
//-----------------------------------------------------------------------------
module serial_pad_reader #(
    parameter int unsigned POLL_CYCLES     = 65536,
    parameter int unsigned LATCH_CYCLES    = 64,
    parameter int unsigned HALF_BIT_CYCLES = 32,
    parameter int unsigned STABLE_POLLS    = 2,
    parameter int unsigned SOCD_CLEAN      = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data,
    output logic [7:0] buttons,
    output logic       poll_done
);

    // One shared phase counter. It must hold the longest of the three phase
    // lengths.
    localparam int unsigned MAX_A    = (POLL_CYCLES > LATCH_CYCLES) ? POLL_CYCLES : LATCH_CYCLES;
    localparam int unsigned MAX_WAIT = (MAX_A > HALF_BIT_CYCLES) ? MAX_A : HALF_BIT_CYCLES;
    localparam int unsigned CW       = $clog2(MAX_WAIT + 1);
    localparam int unsigned SW       = $clog2(STABLE_POLLS + 1);

    localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_BIT_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_POLLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_frame;      // wire order: bit0 = A ... bit7 = Right
    logic            r_sync1;
    logic            r_sync2;
    logic [7:0]      r_cand;
    logic [SW-1:0]   r_stable;
    logic [7:0]      r_buttons;
    logic            r_pad_latch;
    logic            r_pad_clk;
    logic            r_poll_done;

    logic            w_phase_end;
    logic [7:0]      w_raw;
    logic [7:0]      w_clean;
    logic [SW-1:0]   w_stable_inc;

    //-------------------------------------------------------------------------
    // Input synchroniser. It is preset to 1 so a freshly reset reader sees
    // "released".
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= pad_data;
            r_sync2 <= r_sync1;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: phase-end detection and next state
    //-------------------------------------------------------------------------
    always_comb begin
        w_phase_end = 1'b0;
        w_next      = r_state;
        unique case (r_state)
            S_IDLE: begin
                w_phase_end = (r_cnt == POLL_LAST);
                if (w_phase_end) w_next = S_LATCH;
            end
            S_LATCH: begin
                w_phase_end = (r_cnt == LATCH_LAST);
                if (w_phase_end) w_next = S_LOW;
            end
            S_LOW: begin
                w_phase_end = (r_cnt == HALF_LAST);
                if (w_phase_end) w_next = S_HIGH;
            end
            S_HIGH: begin
                w_phase_end = (r_cnt == HALF_LAST);
                if (w_phase_end) w_next = (r_bit == 3'd7) ? S_DONE : S_LOW;
            end
            S_DONE: begin
                w_phase_end = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                w_phase_end = 1'b1;
                w_next      = S_IDLE;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Phase counter, bit index and frame capture
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_frame <= '1;
        end else begin
            if (w_phase_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            // The bit index wraps 7 -> 0 at the end of the last high phase,
            // so it is already zero for the next frame.
            if (r_state == S_HIGH && w_phase_end) begin
                r_bit <= r_bit + 3'd1;
            end

            if (r_state == S_LOW && w_phase_end) begin
                r_frame[r_bit] <= r_sync2;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Pad strobes and done pulse are registered from the next state. Each
    // one is therefore glitch-free and aligned with the state it belongs to.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b1;
            r_poll_done <= 1'b0;
        end else begin
            r_pad_latch <= (w_next == S_LATCH);
            r_pad_clk   <= (w_next != S_LOW);
            r_poll_done <= (w_next == S_DONE);
        end
    end

    //-------------------------------------------------------------------------
    // Remap wire order to console order, then clean opposing directions
    //-------------------------------------------------------------------------
    always_comb begin
        w_raw = {r_frame[3], r_frame[2], r_frame[1], r_frame[0],
                 r_frame[5], r_frame[4], r_frame[6], r_frame[7]};
        w_clean = w_raw;
        if (SOCD_CLEAN != 0) begin
            if (w_raw[3:2] == 2'b00) w_clean[3:2] = 2'b11;
            if (w_raw[1:0] == 2'b00) w_clean[1:0] = 2'b11;
        end
    end

    //-------------------------------------------------------------------------
    // Debounce: publish a frame once it has been seen STABLE_POLLS times in a
    // row.
    //-------------------------------------------------------------------------
    always_comb begin
        w_stable_inc = (r_stable == STABLE_MAX) ? r_stable : r_stable + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand    <= '1;
            r_stable  <= '0;
            r_buttons <= '1;
        end else if (r_state == S_DONE) begin
            if (w_clean != r_cand) begin
                r_cand   <= w_clean;
                r_stable <= SW'(1);
                if (STABLE_POLLS == 1) begin
                    r_buttons <= w_clean;
                end
            end else begin
                r_stable <= w_stable_inc;
                if (w_stable_inc == STABLE_MAX) begin
                    r_buttons <= r_cand;
                end
            end
        end
    end

    assign pad_latch = r_pad_latch;
    assign pad_clk   = r_pad_clk;
    assign poll_done = r_poll_done;
    assign buttons   = r_buttons;

endmodule

// File: tb/tb_serial_pad_reader.sv
module tb_serial_pad_reader;

    localparam int POLL   = 200;
    localparam int LATCH  = 6;
    localparam int HALF   = 4;
    localparam int STABLE = 2;
    localparam int PERIOD = POLL + LATCH + 16 * HALF + 1;

    logic       clk;
    logic       reset;
    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data;
    logic [7:0] buttons;
    logic       poll_done;

    logic [7:0] pad_state;        // pad's buttons in wire order, 0 = pressed

    int         checks;
    int         passes;
    logic [7:0] sb[$];            // expected buttons after each completed frame
    logic [7:0] hist[$];          // reference: cleaned frames since reset
    logic [7:0] model_btn;

    serial_pad_reader #(
        .POLL_CYCLES    (POLL),
        .LATCH_CYCLES   (LATCH),
        .HALF_BIT_CYCLES(HALF),
        .STABLE_POLLS   (STABLE),
        .SOCD_CLEAN     (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pad_latch(pad_latch),
        .pad_clk  (pad_clk),
        .pad_data (pad_data),
        .buttons  (buttons),
        .poll_done(poll_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference model: name the buttons, apply the cleaning rule, and
    // publish a frame once the last STABLE frames are identical.
    function automatic logic [7:0] clean(input logic [7:0] w);
        logic a, b, sel, st, up, dn, lt, rt;
        a = w[0]; b = w[1]; sel = w[2]; st = w[3];
        up = w[4]; dn = w[5]; lt = w[6]; rt = w[7];
        if (!up && !dn) begin up = 1'b1; dn = 1'b1; end
        if (!lt && !rt) begin lt = 1'b1; rt = 1'b1; end
        return {st, sel, b, a, dn, up, lt, rt};
    endfunction

    task automatic model_reset();
        hist.delete();
        model_btn = 8'hFF;
    endtask

    task automatic model_step(input logic [7:0] w);
        bit same;
        hist.push_back(clean(w));
        if (hist.size() >= STABLE) begin
            same = 1'b1;
            for (int k = 1; k < STABLE; k++)
                if (hist[hist.size() - 1 - k] != hist[hist.size() - 1]) same = 1'b0;
            if (same) model_btn = hist[hist.size() - 1];
        end
        sb.push_back(model_btn);
    endtask

    // Pad model: 4021-style shift register. Data lines are valid while
    // pad_clk is low. While pad_clk is high the line toggles at random to
    // exercise the synchroniser.
    initial begin
        logic [7:0] sh;
        logic       pc;
        sh = 8'hFF; pc = 1'b1; pad_data = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (pad_latch) sh = pad_state;
            else if (pad_clk && !pc) sh = {1'b1, sh[7:1]};
            pc = pad_clk;
            if (!pad_clk || pad_latch) begin
                pad_data = sh[0];
            end else begin
                pad_data = 1'($urandom % 2);
                #2 pad_data = 1'($urandom % 2);
            end
        end
    end

    // Scoreboard monitor: compares buttons on the cycle after each poll_done.
    // It also flags any buttons change at any other time.
    initial begin
        logic [7:0] prev_b;
        logic [7:0] exp;
        bit         prev_done;
        prev_b = 8'hFF; prev_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) begin
                    if (sb.size() == 0) fail_now("scoreboard_empty");
                    else begin
                        exp = sb.pop_front();
                        check_v("buttons", 32'(buttons), 32'(exp));
                    end
                end else if (buttons !== prev_b) begin
                    check_v("buttons_midframe", 32'(buttons), 32'(prev_b));
                end
                prev_done = poll_done;
            end
            prev_b = buttons;
        end
    end

    // Waveform timing monitor
    initial begin
        bit pl, pc, dv;
        int ll, lowl, nlow, cyc, lastd;
        pl = 1'b0; pc = 1'b1; dv = 1'b0; ll = 0; lowl = 0; nlow = 0; cyc = 0; lastd = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (reset) begin
                pl = 1'b0; pc = 1'b1; dv = 1'b0; ll = 0; lowl = 0; nlow = 0;
            end else begin
                if (pad_latch) begin
                    if (!pl) nlow = 0;
                    ll++;
                end else if (pl) begin
                    check_v("latch_width", 32'(ll), 32'(LATCH));
                    ll = 0;
                end
                if (!pad_clk) lowl++;
                else if (!pc) begin
                    check_v("low_width", 32'(lowl), 32'(HALF));
                    nlow++;
                    lowl = 0;
                end
                if (poll_done) begin
                    check_v("low_pulses", 32'(nlow), 32'd8);
                    if (dv) check_v("frame_period", 32'(cyc - lastd), 32'(PERIOD));
                    dv = 1'b1;
                    lastd = cyc;
                end
                pl = pad_latch;
                pc = pad_clk;
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!poll_done && n < 2 * PERIOD);
        if (!poll_done) fail_now("poll_done_timeout");
    endtask

    task automatic run_frame(input logic [7:0] w);
        pad_state = w;
        model_step(w);
        wait_done();
    endtask

    // Releases reset just after an edge and measures how long it takes the
    // latch to rise.
    task automatic release_and_measure();
        int n;
        reset = 1'b0;
        n = 0;
        while (!pad_latch && n < 2 * PERIOD) begin
            @(posedge clk); #1;
            n++;
        end
        check_v("latch_latency", 32'(n), 32'(POLL));
    endtask

    initial begin
        int         n, falls;
        logic       prev;
        logic [7:0] w, last_w;

        checks = 0; passes = 0;
        reset = 1'b1;
        pad_state = 8'hFF;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_v("rst_buttons", 32'(buttons), 32'hFF);
        check_v("rst_latch", 32'(pad_latch), 32'd0);
        check_v("rst_padclk", 32'(pad_clk), 32'd1);
        check_v("rst_done", 32'(poll_done), 32'd0);

        // Disconnected pad, then A held for two frames.
        model_step(8'hFF);
        release_and_measure();
        wait_done();
        run_frame(8'hFE);
        run_frame(8'hFE);
        // Start+Up+Down, then B+Left+Right.
        run_frame(8'hC7);
        run_frame(8'hC7);
        run_frame(8'h3D);
        run_frame(8'h3D);

        // Abort a frame during the low phase of bit 4.
        pad_state = 8'h00;
        n = 0;
        while (!pad_latch && n < 2 * PERIOD) begin @(posedge clk); #1; n++; end
        if (!pad_latch) fail_now("latch_wait");
        falls = 0; prev = 1'b1; n = 0;
        while (falls < 5 && n < PERIOD) begin
            @(posedge clk); #1;
            n++;
            if (!pad_clk && prev) falls++;
            prev = pad_clk;
        end
        if (falls < 5) fail_now("bit4_wait");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_v("midrst_padclk", 32'(pad_clk), 32'd1);
        check_v("midrst_latch", 32'(pad_latch), 32'd0);
        check_v("midrst_buttons", 32'(buttons), 32'hFF);
        check_v("midrst_done", 32'(poll_done), 32'd0);
        check_v("midrst_pending", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;

        // Alternating A after reset must never publish anything.
        model_reset();
        pad_state = 8'hFE;
        model_step(8'hFE);
        release_and_measure();
        wait_done();
        for (int i = 0; i < 5; i++) run_frame((i % 2 == 0) ? 8'hFF : 8'hFE);

        // Random sparse presses, often repeated so the debouncer publishes.
        last_w = 8'hFF;
        for (int i = 0; i < 30; i++) begin
            if ($urandom % 2 == 0) w = last_w;
            else w = ~(8'($urandom) & 8'($urandom));
            run_frame(w);
            last_w = w;
        end

        repeat (3) @(posedge clk);
        #1;
        check_v("final_pending", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
